mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port `memory` block between the instruction-fetch port (I) and the load/store port (D) of the riscy32 core. It picks one request per cycle, drives the memory's `write_enable`/`address`/`data_in`, and returns read data one cycle later on the granted port's response channel. It sits between the core's fetch/LSU logic and `memory`.

---
 rtl/mem_arbiter_if.sv | 43 ++++
 rtl/mem_arbiter.sv | 91 +++++++++
 tb/tb_mem_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Request/response and memory-side bundle for mem_arbiter; slave = arbiter, master = core + memory side.
// Request channels are valid/ready; response channels are valid-only and never stall.
interface mem_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  i_req_valid;
   logic                  i_req_ready;
   logic [ADDR_WIDTH-1:0] i_req_addr;
   logic                  i_rsp_valid;
   logic [DATA_WIDTH-1:0] i_rsp_data;

   logic                  d_req_valid;
   logic                  d_req_ready;
   logic                  d_req_we;
   logic [ADDR_WIDTH-1:0] d_req_addr;
   logic [DATA_WIDTH-1:0] d_req_wdata;
   logic                  d_rsp_valid;
   logic [DATA_WIDTH-1:0] d_rsp_data;

   logic                  mem_write_enable;
   logic [ADDR_WIDTH-1:0] mem_address;
   logic [DATA_WIDTH-1:0] mem_data_in;
   logic [DATA_WIDTH-1:0] mem_data_out;

   modport slave (
      input  i_req_valid, i_req_addr,
      output i_req_ready, i_rsp_valid, i_rsp_data,
      input  d_req_valid, d_req_we, d_req_addr, d_req_wdata,
      output d_req_ready, d_rsp_valid, d_rsp_data,
      output mem_write_enable, mem_address, mem_data_in,
      input  mem_data_out
   );

   modport master (
      output i_req_valid, i_req_addr,
      input  i_req_ready, i_rsp_valid, i_rsp_data,
      output d_req_valid, d_req_we, d_req_addr, d_req_wdata,
      input  d_req_ready, d_rsp_valid, d_rsp_data,
      input  mem_write_enable, mem_address, mem_data_in,
      output mem_data_out
   );
endinterface

// File: rtl/mem_arbiter.sv
// I/D arbiter for a single-port memory; MEM_ARB_ROUND_ROBIN_EN selects round-robin, else D-first fixed priority.
// Grant in cycle N, response in N+1 (1 req/cycle); zero-cycle ready, responses never stall.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic         clk,
   input  logic         reset,
   mem_arbiter_if.slave bus
);
   typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_e;

   typedef struct packed {
      logic  vld;
      port_e port;
      logic  we;
   } pend_t;

   pend_t                 pend_q, pend_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  d_wins;
   logic                  grant_i, grant_d;
   logic                  rsp_live;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   port_e last_q, last_d;

   always_comb begin
      last_d = last_q;
      if (grant_d)      last_d = PORT_D;
      else if (grant_i) last_d = PORT_I;
   end

   // Pointer resets to "I granted last" so that D wins the first contention.
   always_ff @(posedge clk) begin
      if (reset) last_q <= PORT_I;
      else       last_q <= last_d;
   end

   assign d_wins = (last_q == PORT_I);
`else
   assign d_wins = 1'b1;
`endif

   always_comb begin
      grant_i = !reset && bus.i_req_valid && (!bus.d_req_valid || !d_wins);
      grant_d = !reset && bus.d_req_valid && (!bus.i_req_valid || d_wins);
   end

   assign bus.i_req_ready = grant_i;
   assign bus.d_req_ready = grant_d;

   // Memory address/data hold their last driven value whenever nothing is granted.
   always_comb begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
      pend_d  = '0;
      if (grant_d) begin
         addr_d  = bus.d_req_addr;
         wdata_d = bus.d_req_wdata;
         pend_d  = '{vld: 1'b1, port: PORT_D, we: bus.d_req_we};
      end else if (grant_i) begin
         addr_d  = bus.i_req_addr;
         pend_d  = '{vld: 1'b1, port: PORT_I, we: 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         pend_q  <= pend_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign bus.mem_write_enable = grant_d && bus.d_req_we;
   assign bus.mem_address      = addr_d;
   assign bus.mem_data_in      = wdata_d;

   // A response still in flight when reset rises is dropped.
   assign rsp_live        = pend_q.vld && !reset;
   assign bus.i_rsp_valid = rsp_live && (pend_q.port == PORT_I);
   assign bus.d_rsp_valid = rsp_live && (pend_q.port == PORT_D);
   assign bus.i_rsp_data  = bus.i_rsp_valid ? bus.mem_data_out : '0;
   assign bus.d_rsp_data  = (bus.d_rsp_valid && !pend_q.we) ? bus.mem_data_out : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the driver queues expected responses, a negedge monitor pops and compares.
// Includes a synchronous-read 4096-word memory model indexed by the low 12 address bits.
module tb_mem_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic tb_init = 1'b1;
   int   vecs = 0;
   int   errs = 0;

   typedef struct {
      bit          port;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];

   mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:4095];
   logic [31:0] mem_dout = 32'h0;

   function automatic logic [31:0] init_val(input int a);
      if (a == 'h4)                  return 32'h1111_0004;
      if (a == 'h8)                  return 32'h2222_0008;
      if (a >= 'h20 && a <= 'h27)    return 32'(2 * a);
      if (a == 'h30)                 return 32'h3030_3030;
      return 32'h0;
   endfunction

   always @(posedge clk) begin
      if (tb_init) begin
         for (int i = 0; i < 4096; i++) mem[i] <= init_val(i);
      end else if (bus.mem_write_enable) begin
         mem[bus.mem_address[11:0]] <= bus.mem_data_in;
      end
      mem_dout <= mem[bus.mem_address[11:0]];
   end
   assign bus.mem_data_out = mem_dout;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every response must match the oldest queued expectation.
   always @(negedge clk) begin
      if (bus.i_rsp_valid && bus.d_rsp_valid) chk("rsp_both_ports", 32'd1, 32'd0);
      if (bus.i_rsp_valid || bus.d_rsp_valid) begin
         if (exp_q.size() == 0) begin
            chk("rsp_unexpected", {31'd0, bus.d_rsp_valid}, 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rsp_port", {31'd0, bus.d_rsp_valid}, {31'd0, e.port});
            chk("rsp_data", bus.d_rsp_valid ? bus.d_rsp_data : bus.i_rsp_data, e.data);
         end
      end
   end

   // Drive one cycle's inputs after the edge, check readies/write-enable at negedge, queue the response.
   task automatic step(input bit rst, input bit iv, input logic [31:0] ia,
                       input bit dv, input bit dwe, input logic [31:0] da, input logic [31:0] dw,
                       input bit exp_ir, input bit exp_dr, input bit push, input logic [31:0] exp_data);
      exp_t e;
      @(posedge clk);
      #1;
      reset           = rst;
      bus.i_req_valid = iv;
      bus.i_req_addr  = ia;
      bus.d_req_valid = dv;
      bus.d_req_we    = dwe;
      bus.d_req_addr  = da;
      bus.d_req_wdata = dw;
      @(negedge clk);
      chk("i_req_ready", {31'd0, bus.i_req_ready}, {31'd0, exp_ir});
      chk("d_req_ready", {31'd0, bus.d_req_ready}, {31'd0, exp_dr});
      chk("mem_we", {31'd0, bus.mem_write_enable}, {31'd0, exp_dr && dwe});
      if (push && (exp_ir || exp_dr)) begin
         e.port = exp_dr;
         e.data = exp_data;
         exp_q.push_back(e);
      end
   endtask

   initial begin
      bus.i_req_valid = 1'b1;
      bus.i_req_addr  = 32'h4;
      bus.d_req_valid = 1'b1;
      bus.d_req_we    = 1'b0;
      bus.d_req_addr  = 32'h8;
      bus.d_req_wdata = 32'h0;

      // Reset held two cycles with both requesters valid.
      step(1, 1, 32'h4, 1, 0, 32'h8, 32'h0, 0, 0, 0, 32'h0);
      tb_init = 1'b0;
      step(1, 1, 32'h4, 1, 0, 32'h8, 32'h0, 0, 0, 0, 32'h0);
      chk("rst_i_rsp_valid", {31'd0, bus.i_rsp_valid}, 32'd0);
      chk("rst_d_rsp_valid", {31'd0, bus.d_rsp_valid}, 32'd0);
      chk("rst_i_rsp_data", bus.i_rsp_data, 32'h0);
      chk("rst_d_rsp_data", bus.d_rsp_data, 32'h0);
      chk("rst_mem_address", bus.mem_address, 32'h0);
      chk("rst_mem_data_in", bus.mem_data_in, 32'h0);

      // Contention for 4 cycles: D wins the first one in both builds.
      step(0, 1, 32'h4, 1, 0, 32'h8, 32'h0, 0, 1, 1, 32'h2222_0008);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      step(0, 1, 32'h4, 1, 0, 32'h8, 32'h0, 1, 0, 1, 32'h1111_0004);
      step(0, 1, 32'h4, 1, 0, 32'h8, 32'h0, 0, 1, 1, 32'h2222_0008);
      step(0, 1, 32'h4, 1, 0, 32'h8, 32'h0, 1, 0, 1, 32'h1111_0004);
`else
      step(0, 1, 32'h4, 1, 0, 32'h8, 32'h0, 0, 1, 1, 32'h2222_0008);
      step(0, 1, 32'h4, 1, 0, 32'h8, 32'h0, 0, 1, 1, 32'h2222_0008);
      step(0, 1, 32'h4, 1, 0, 32'h8, 32'h0, 0, 1, 1, 32'h2222_0008);
`endif

      // Store then load of the same address back to back.
      step(0, 0, 32'h0, 1, 1, 32'h10, 32'hDEAD_BEEF, 0, 1, 1, 32'h0);
      chk("st_mem_address", bus.mem_address, 32'h10);
      chk("st_mem_data_in", bus.mem_data_in, 32'hDEAD_BEEF);
      step(0, 0, 32'h0, 1, 0, 32'h10, 32'h1234_5678, 0, 1, 1, 32'hDEAD_BEEF);

      // Idle: memory address/data hold the last driven values.
      step(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
      chk("idle_mem_address", bus.mem_address, 32'h10);
      chk("idle_mem_data_in", bus.mem_data_in, 32'h1234_5678);

      // Back-to-back fetches 0x20..0x27.
      for (int k = 0; k < 8; k++) begin
         step(0, 1, 32'h20 + 32'(k), 0, 0, 32'h0, 32'h0, 1, 0, 1, 32'h40 + 32'(2 * k));
      end
      step(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0);

      // Load granted, then reset the next cycle with a store pending: no response, no write.
      step(0, 0, 32'h0, 1, 0, 32'h8, 32'h0, 0, 1, 0, 32'h0);
      step(1, 0, 32'h0, 1, 1, 32'h30, 32'hBAD0_BAD0, 0, 0, 0, 32'h0);
      chk("midrst_d_rsp_valid", {31'd0, bus.d_rsp_valid}, 32'd0);
      step(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
      step(0, 0, 32'h0, 1, 0, 32'h30, 32'h0, 0, 1, 1, 32'h3030_3030);
      step(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
      step(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0);

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
